star_cam_sub: RTL and testbench

STAR_CAM_SUB -- requirements
Module: star_cam_sub

---
 rtl/star_cam_sub.sv | 129 ++++++++++++
 tb/tb_star_cam_sub.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/star_cam_sub.sv
// Sorted-threshold CAM: maps a value to the one-hot index of the largest entry not above it,
// and converts a pair of match vectors into a one-hot index distance.
module star_cam_sub #(
  parameter int LUT_LEN = 64,
  parameter int EXP_LEN = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lut_we,
  input  logic [5:0]         lut_waddr,
  input  logic [7:0]         lut_wdata,
  output logic               lut_ready,
  input  logic               CAMSUB_req,
  input  logic [7:0]         xi,
  output logic [LUT_LEN-1:0] xi_mv,
  output logic               xi_mv_valid,
  input  logic               FindSub_req,
  input  logic [LUT_LEN-1:0] xmax_mv,
  input  logic [LUT_LEN-1:0] xsrc_mv,
  output logic [EXP_LEN-1:0] sub_mv,
  output logic               sub_mv_valid,
  output logic               err,
  output logic               fsm_state
);

  localparam int AW = $clog2(LUT_LEN);
  localparam logic [AW-1:0] SAT = AW'(EXP_LEN - 1);

  typedef enum logic {LOAD = 1'b0, ACTIVE = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [LUT_LEN-1:0] written;
  logic [7:0]         entry [LUT_LEN];

  logic               wr_go, lu_go, sub_go, err_set;
  logic               lu_hit;
  logic [AW-1:0]      lu_idx;
  logic [LUT_LEN-1:0] lu_vec;
  logic               im_ok, is_ok, sub_bad;
  logic [AW-1:0]      im, is, diff;
  logic [EXP_LEN-1:0] sub_vec;

  // Requests carry no ready: a request is accepted when it is high in ACTIVE, and its
  // valid output pulses for exactly the following cycle with data held otherwise.
  always_comb begin
    state_nxt = state;
    wr_go     = 1'b0;
    lu_go     = 1'b0;
    sub_go    = 1'b0;
    err_set   = 1'b0;
    case (state)
      LOAD: begin
        if (&written) state_nxt = ACTIVE;
        wr_go   = lut_we;
        err_set = CAMSUB_req | FindSub_req;
      end
      ACTIVE: begin
        lu_go   = CAMSUB_req;
        sub_go  = FindSub_req & ~CAMSUB_req;
        err_set = lut_we | (CAMSUB_req & FindSub_req) | (sub_go & sub_bad);
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Entries are loaded in ascending order, so the last passing index is the largest one.
  always_comb begin
    lu_hit = 1'b0;
    lu_idx = '0;
    for (int k = 0; k < LUT_LEN; k++) begin
      if (entry[k] <= xi) begin
        lu_hit = 1'b1;
        lu_idx = AW'(k);
      end
    end
    lu_vec = lu_hit ? (LUT_LEN'(1) << lu_idx) : '0;
  end

  always_comb begin
    im_ok = 1'b0;
    is_ok = 1'b0;
    im    = '0;
    is    = '0;
    for (int k = 0; k < LUT_LEN; k++) begin
      if (xmax_mv[k]) begin
        im_ok = 1'b1;
        im    = AW'(k);
      end
      if (xsrc_mv[k]) begin
        is_ok = 1'b1;
        is    = AW'(k);
      end
    end
    sub_bad = ~im_ok | ~is_ok | (im < is);
    diff    = im - is;
    if (sub_bad)         sub_vec = '0;
    else if (diff > SAT) sub_vec = EXP_LEN'(1) << SAT;
    else                 sub_vec = EXP_LEN'(1) << diff;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= LOAD;
      written      <= '0;
      xi_mv        <= '0;
      xi_mv_valid  <= 1'b0;
      sub_mv       <= '0;
      sub_mv_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_nxt;
      if (wr_go) written[lut_waddr] <= 1'b1;
      xi_mv_valid  <= lu_go;
      if (lu_go) xi_mv <= lu_vec;
      sub_mv_valid <= sub_go;
      if (sub_go) sub_mv <= sub_vec;
      if (err_set) err <= 1'b1;
    end
  end

  // Table contents are not reset; the written mask gates use until a full reload.
  always_ff @(posedge clk) begin
    if (wr_go) entry[lut_waddr] <= lut_wdata;
  end

  assign lut_ready = (state == ACTIVE);
  assign fsm_state = state;

endmodule

// File: tb/tb_star_cam_sub.sv
// Bench for star_cam_sub: directed and random steps checked against a table-scan reference model.
module tb_star_cam_sub;
  localparam int LUT_LEN = 64;
  localparam int EXP_LEN = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               lut_we;
  logic [5:0]         lut_waddr;
  logic [7:0]         lut_wdata;
  logic               lut_ready;
  logic               CAMSUB_req;
  logic [7:0]         xi;
  logic [LUT_LEN-1:0] xi_mv;
  logic               xi_mv_valid;
  logic               FindSub_req;
  logic [LUT_LEN-1:0] xmax_mv;
  logic [LUT_LEN-1:0] xsrc_mv;
  logic [EXP_LEN-1:0] sub_mv;
  logic               sub_mv_valid;
  logic               err;
  logic               fsm_state;

  star_cam_sub #(.LUT_LEN(LUT_LEN), .EXP_LEN(EXP_LEN)) dut (
    .clk(clk), .reset(reset),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .lut_ready(lut_ready),
    .CAMSUB_req(CAMSUB_req), .xi(xi), .xi_mv(xi_mv), .xi_mv_valid(xi_mv_valid),
    .FindSub_req(FindSub_req), .xmax_mv(xmax_mv), .xsrc_mv(xsrc_mv),
    .sub_mv(sub_mv), .sub_mv_valid(sub_mv_valid), .err(err), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0]         m_entry [LUT_LEN];
  bit                 m_written [LUT_LEN];
  bit                 m_active, m_err, m_xv, m_sv;
  logic [LUT_LEN-1:0] m_xi_mv;
  logic [EXP_LEN-1:0] m_sub_mv;
  logic [LUT_LEN-1:0] exp_q [$];
  logic [7:0]         tbl [LUT_LEN];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit all_written();
    for (int k = 0; k < LUT_LEN; k++) if (!m_written[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [LUT_LEN-1:0] ref_lookup(input int x);
    logic [LUT_LEN-1:0] r;
    r = '0;
    for (int k = LUT_LEN - 1; k >= 0; k--) begin
      if (int'(m_entry[k]) <= x) begin
        r[k] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  function automatic int top_bit(input logic [LUT_LEN-1:0] v);
    for (int k = LUT_LEN - 1; k >= 0; k--) if (v[k]) return k;
    return -1;
  endfunction

  function automatic logic [LUT_LEN-1:0] bit_at(input int k);
    logic [LUT_LEN-1:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < LUT_LEN; k++) m_written[k] = 1'b0;
    m_active = 1'b0; m_err = 1'b0; m_xv = 1'b0; m_sv = 1'b0;
    m_xi_mv = '0; m_sub_mv = '0;
    exp_q.delete();
  endtask

  task automatic compare_all(input string tag);
    logic [LUT_LEN-1:0] e;
    check({tag, "/lut_ready"}, 64'(lut_ready), 64'(m_active));
    check({tag, "/fsm_state"}, 64'(fsm_state), 64'(m_active));
    check({tag, "/xi_mv_valid"}, 64'(xi_mv_valid), 64'(m_xv));
    check({tag, "/sub_mv_valid"}, 64'(sub_mv_valid), 64'(m_sv));
    check({tag, "/err"}, 64'(err), 64'(m_err));
    check({tag, "/sub_mv"}, 64'(sub_mv), 64'(m_sub_mv));
    if (m_xv && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "/xi_mv"}, 64'(xi_mv), 64'(e));
    end else begin
      check({tag, "/xi_mv_hold"}, 64'(xi_mv), 64'(m_xi_mv));
    end
  endtask

  // driver: one clock of stimulus, model update, then sampling after the edge
  task automatic cycle(input string tag, input bit we, input int wa, input int wd,
                       input bit creq, input int x, input bit freq,
                       input logic [LUT_LEN-1:0] xmax, input logic [LUT_LEN-1:0] xsrc);
    bit nxt;
    int im, is, d;
    @(negedge clk);
    lut_we = we; lut_waddr = wa[5:0]; lut_wdata = wd[7:0];
    CAMSUB_req = creq; xi = x[7:0];
    FindSub_req = freq; xmax_mv = xmax; xsrc_mv = xsrc;
    m_xv = 1'b0;
    m_sv = 1'b0;
    if (!m_active) begin
      nxt = all_written();
      if (we) begin
        m_entry[wa] = wd[7:0];
        m_written[wa] = 1'b1;
      end
      if (creq || freq) m_err = 1'b1;
      m_active = nxt;
    end else begin
      if (we) m_err = 1'b1;
      if (creq) begin
        m_xi_mv = ref_lookup(x);
        m_xv = 1'b1;
        exp_q.push_back(m_xi_mv);
        if (freq) m_err = 1'b1;
      end else if (freq) begin
        m_sv = 1'b1;
        im = top_bit(xmax);
        is = top_bit(xsrc);
        if (im < 0 || is < 0 || im < is) begin
          m_sub_mv = '0;
          m_err = 1'b1;
        end else begin
          d = im - is;
          if (d > EXP_LEN - 1) d = EXP_LEN - 1;
          m_sub_mv = '0;
          m_sub_mv[d] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 0, 0, 0, 0, 0, 0, '0, '0);
  endtask

  task automatic lookup(input string tag, input int x);
    cycle(tag, 0, 0, 0, 1, x, 0, '0, '0);
  endtask

  task automatic subtract(input string tag, input logic [LUT_LEN-1:0] a, input logic [LUT_LEN-1:0] b);
    cycle(tag, 0, 0, 0, 0, 0, 1, a, b);
  endtask

  task automatic reset_now(input string tag);
    reset = 1'b1;
    lut_we = 0; CAMSUB_req = 0; FindSub_req = 0;
    #1;
    model_reset();
    compare_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_now(tag);
  endtask

  task automatic load_shuffled();
    int order [LUT_LEN];
    int j, t;
    for (int k = 0; k < LUT_LEN; k++) order[k] = k;
    for (int k = LUT_LEN - 1; k > 0; k--) begin
      j = $urandom_range(0, k);
      t = order[k]; order[k] = order[j]; order[j] = t;
    end
    for (int k = 0; k < LUT_LEN; k++) cycle("load_rand", 1, order[k], tbl[order[k]], 0, 0, 0, '0, '0);
    idle("load_rand_full");
    idle("load_rand_ready");
  endtask

  task automatic random_table();
    int v;
    v = $urandom_range(1, 10);
    for (int k = 0; k < LUT_LEN; k++) begin
      tbl[k] = v[7:0];
      v = v + $urandom_range(0, 3);
    end
  endtask

  task automatic random_subs(input int n, input bit allow_bad);
    int a, b;
    logic [LUT_LEN-1:0] va, vb;
    for (int i = 0; i < n; i++) begin
      a = $urandom_range(0, LUT_LEN - 1);
      b = allow_bad ? $urandom_range(0, LUT_LEN - 1) : $urandom_range(0, a);
      va = bit_at(a) | ({$urandom, $urandom} & (bit_at(a) - 1));
      vb = bit_at(b) | ({$urandom, $urandom} & (bit_at(b) - 1));
      if (allow_bad && $urandom_range(0, 7) == 0) vb = '0;
      subtract("sub_rand", va, vb);
    end
  endtask

  initial begin
    reset = 1'b1;
    lut_we = 0; lut_waddr = '0; lut_wdata = '0;
    CAMSUB_req = 0; xi = '0; FindSub_req = 0; xmax_mv = '0; xsrc_mv = '0;
    model_reset();
    do_reset("reset");

    // requests while loading are dropped and flagged
    lookup("load_req", 9);
    subtract("load_sub", bit_at(4), bit_at(1));
    do_reset("reset2");

    // table of 4k with one duplicate rewrite before the final entry
    for (int k = 0; k < LUT_LEN; k++) tbl[k] = 8'(4 * k);
    for (int k = 0; k < LUT_LEN - 1; k++) cycle("load", 1, k, tbl[k], 0, 0, 0, '0, '0);
    cycle("load_dup", 1, 5, tbl[5], 0, 0, 0, '0, '0);
    idle("dup_wait1");
    idle("dup_wait2");
    cycle("load_last", 1, 63, tbl[63], 0, 0, 0, '0, '0);
    check("ready_not_yet", 64'(lut_ready), 64'd0);
    idle("load_full");
    check("ready_up", 64'(lut_ready), 64'd1);
    check("load_no_err", 64'(err), 64'd0);

    lookup("xi9", 9);
    check("xi9_val", 64'(xi_mv), 64'h4);
    lookup("xi255", 255);
    check("xi255_val", 64'(xi_mv), 64'h8000_0000_0000_0000);
    lookup("xi0", 0);
    check("xi0_val", 64'(xi_mv), 64'h1);
    lookup("xi8", 8);
    check("xi8_val", 64'(xi_mv), 64'h4);
    lookup("xi12", 12);
    check("xi12_val", 64'(xi_mv), 64'h8);
    idle("lk_hold");
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) idle("lk_gap");
      lookup("lk_rand", $urandom_range(0, 255));
    end

    subtract("sub_20_17", bit_at(20), bit_at(17));
    check("sub_20_17_val", 64'(sub_mv), 64'h0008);
    subtract("sub_40_2", bit_at(40), bit_at(2));
    check("sub_40_2_val", 64'(sub_mv), 64'h8000);
    idle("sub_hold");
    random_subs(30, 1'b0);
    check("sub_no_err", 64'(err), 64'd0);
    subtract("sub_3_5", bit_at(3), bit_at(5));
    check("sub_3_5_val", 64'(sub_mv), 64'h0);
    check("sub_3_5_err", 64'(err), 64'd1);
    subtract("sub_zero", '0, bit_at(5));

    // write in ACTIVE is ignored
    cycle("we_active", 1, 2, 200, 0, 0, 0, '0, '0);
    lookup("xi9_after_we", 9);
    check("xi9_after_we_val", 64'(xi_mv), 64'h4);

    cycle("collide", 0, 0, 0, 1, 100, 1, bit_at(9), bit_at(1));
    check("collide_sv", 64'(sub_mv_valid), 64'd0);

    // random table with equal runs, loaded out of order
    do_reset("reset3");
    random_table();
    load_shuffled();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0) lookup("lk_rand2", $urandom_range(0, 200));
      else lookup("lk_near", int'(tbl[$urandom_range(0, LUT_LEN - 1)]) + $urandom_range(0, 1));
    end
    lookup("below_min", int'(tbl[0]) - 1);
    check("below_min_val", 64'(xi_mv), 64'h0);
    random_subs(40, 1'b1);

    // reset right after an accepted lookup cancels its pulse
    lookup("mid_req", 50);
    reset_now("mid_reset");
    check("mid_reset_xv", 64'(xi_mv_valid), 64'd0);
    idle("post_reset1");
    idle("post_reset2");
    check("post_reset_ready", 64'(lut_ready), 64'd0);
    random_table();
    load_shuffled();
    for (int i = 0; i < 20; i++) lookup("lk_reload", $urandom_range(0, 255));
    idle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
